// File: rtl/ir_tx.sv
// ir_tx -- NEC IR transmitter (unmodulated pulse-distance waveform).
//
// Accepts an address/command pair on a valid/ready handshake, builds the
// frame {~cmd, cmd, ~addr, addr} and sends it LSB first:
//   start burst, start space, per bit (burst + short/long space), stop burst,
//   then a mandatory low guard gap before the next frame can be accepted.
// Line level: 1 = burst, 0 = space, idle low.
//
// Ports:
//   i_clkDiv_tx_clk  tick clock (FREQ_MHz ticks per microsecond)
//   i_tx_rst_n       asynchronous active-low reset
//   i_tx_valid       send request, qualifies i_tx_addr / i_tx_cmd
//   o_tx_ready       high only when idle; transfer on valid && ready
//   i_tx_addr        address field
//   i_tx_cmd         command field
//   o_tx_dataOut     registered IR line
//   o_tx_busy        high whenever not idle
//   o_tx_done        one-cycle pulse on the edge that leaves the guard gap
module ir_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int FREQ_MHz   = 1,
  parameter int GAP_DUR    = 40_000
) (
  input  logic                  i_clkDiv_tx_clk,
  input  logic                  i_tx_rst_n,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  input  logic [DATA_WIDTH-1:0] i_tx_addr,
  input  logic [DATA_WIDTH-1:0] i_tx_cmd,
  output logic                  o_tx_dataOut,
  output logic                  o_tx_busy,
  output logic                  o_tx_done
);

  localparam int FW         = 4 * DATA_WIDTH;
  localparam int BW         = $clog2(FW + 1);
  localparam int START_PUL  = 9000 * FREQ_MHz;
  localparam int START_SPC  = 4500 * FREQ_MHz;
  localparam int BURST      = 562 * FREQ_MHz;
  localparam int LOW_SPC    = 562 * FREQ_MHz;
  localparam int HIGH_SPC   = 1687 * FREQ_MHz;
  localparam int GAP        = GAP_DUR * FREQ_MHz;
  localparam int MAXT       = (START_PUL > GAP) ? START_PUL : GAP;
  localparam int CW         = $clog2(MAXT) + 1;

  // Terminal counts (N-1) for each segment.
  localparam logic [CW-1:0] L_START_PUL = CW'(START_PUL - 1);
  localparam logic [CW-1:0] L_START_SPC = CW'(START_SPC - 1);
  localparam logic [CW-1:0] L_BURST     = CW'(BURST - 1);
  localparam logic [CW-1:0] L_LOW_SPC   = CW'(LOW_SPC - 1);
  localparam logic [CW-1:0] L_HIGH_SPC  = CW'(HIGH_SPC - 1);
  localparam logic [CW-1:0] L_GAP       = CW'(GAP - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START_PULSE = 3'd1,
    START_SPACE = 3'd2,
    BIT_PULSE   = 3'd3,
    BIT_SPACE   = 3'd4,
    STOP_PULSE  = 3'd5,
    GAP_S       = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            out_q, out_d;
  logic            done_q, done_d;
  logic [CW-1:0]   seg_last;
  logic            seg_end;

  // Terminal count of the segment currently being timed. In BIT_SPACE the
  // length depends on the bit at the bottom of the shift register.
  always_comb begin
    seg_last = '0;
    case (state_q)
      START_PULSE: seg_last = L_START_PUL;
      START_SPACE: seg_last = L_START_SPC;
      BIT_PULSE:   seg_last = L_BURST;
      BIT_SPACE:   seg_last = frame_q[0] ? L_HIGH_SPC : L_LOW_SPC;
      STOP_PULSE:  seg_last = L_BURST;
      GAP_S:       seg_last = L_GAP;
      default:     seg_last = '0;
    endcase
  end

  assign seg_end = (cnt_q == seg_last);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_tx_valid) begin
          state_d = START_PULSE;
          frame_d = {~i_tx_cmd, i_tx_cmd, ~i_tx_addr, i_tx_addr};
          bit_d   = '0;
        end
      end
      START_PULSE: if (seg_end) begin
        cnt_d   = '0;
        state_d = START_SPACE;
      end
      START_SPACE: if (seg_end) begin
        cnt_d   = '0;
        state_d = BIT_PULSE;
      end
      BIT_PULSE: if (seg_end) begin
        cnt_d   = '0;
        state_d = BIT_SPACE;
      end
      BIT_SPACE: if (seg_end) begin
        cnt_d   = '0;
        bit_d   = bit_q + BW'(1);
        frame_d = {1'b0, frame_q[FW-1:1]};
        state_d = (bit_q == BW'(FW - 1)) ? STOP_PULSE : BIT_PULSE;
      end
      STOP_PULSE: if (seg_end) begin
        cnt_d   = '0;
        state_d = GAP_S;
      end
      GAP_S: if (seg_end) begin
        cnt_d   = '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Line is registered from the next state so it lines up with the state
  // register: high from the cycle right after the accept edge.
  assign out_d = (state_d == START_PULSE) || (state_d == BIT_PULSE) ||
                 (state_d == STOP_PULSE);

  always_ff @(posedge i_clkDiv_tx_clk or negedge i_tx_rst_n) begin
    if (!i_tx_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign o_tx_ready   = (state_q == IDLE);
  assign o_tx_busy    = (state_q != IDLE);
  assign o_tx_dataOut = out_q;
  assign o_tx_done    = done_q;

endmodule
